serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor computing `a - b`, LSB first, one bit per clock through a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the team's combinational full-adder cell. It serves as a small sequential arithmetic unit where area matters more than latency. A start/busy/done handshake accepts operand words from, and returns results to, a controlling FSM or testbench.

---
 rtl/serial_subtractor.sv | 138 +++++++++++++
 tb/tb_serial_subtractor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor computing a - b.
// Bits are processed LSB first, one per clock, through a single
// full-subtractor cell and a borrow flip-flop. A start/busy/done handshake
// loads operands and returns the result.
// Optional feature: define SERSUB_OVF_EN to add the registered signed
// overflow output 'ovf' and the operand MSB capture it needs.

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [WIDTH-1:0] r_aSr;
  logic [WIDTH-1:0] r_bSr;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_br;
  logic             r_borrow;

  logic w_x;
  logic w_y;
  logic w_d;
  logic w_brNext;
  logic w_lastBit;

`ifdef SERSUB_OVF_EN
  logic r_aMsb;
  logic r_bMsb;
  logic r_ovf;
`endif

  // Full-subtractor cell on the current LSBs plus the running borrow
  assign w_x      = r_aSr[0];
  assign w_y      = r_bSr[0];
  assign w_d      = w_x ^ w_y ^ r_br;
  assign w_brNext = (~w_x & w_y) | (~w_x & r_br) | (w_y & r_br);
  assign w_lastBit = (r_cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: start only matters in IDLE, DONE lasts one cycle
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = RUN;
      RUN:     if (w_lastBit) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: load operands on accept, shift one bit per RUN cycle,
  // capture the final borrow (and overflow) on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aSr    <= '0;
      r_bSr    <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_br     <= 1'b0;
      r_borrow <= 1'b0;
`ifdef SERSUB_OVF_EN
      r_aMsb   <= 1'b0;
      r_bMsb   <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_aSr <= a;
            r_bSr <= b;
            r_br  <= 1'b0;
            r_cnt <= '0;
`ifdef SERSUB_OVF_EN
            r_aMsb <= a[WIDTH-1];
            r_bMsb <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_aSr  <= {1'b0, r_aSr[WIDTH-1:1]};
          r_bSr  <= {1'b0, r_bSr[WIDTH-1:1]};
          r_br   <= w_brNext;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_lastBit) begin
            r_borrow <= w_brNext;
`ifdef SERSUB_OVF_EN
            r_ovf <= (r_aMsb != r_bMsb) && (w_d != r_aMsb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign diff   = r_diff;
  assign borrow = r_borrow;
`ifdef SERSUB_OVF_EN
  assign ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed, self-checking bench for serial_subtractor
// (WIDTH=8). Expected results come from a word-level subtraction model and
// are queued when an operation is launched, then popped when done is seen.

module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERSUB_OVF_EN
  logic             ovf;
`endif

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             br;
    logic             ov;
  } exp_t;

  exp_t expQ[$];
  int   nCompared;
  int   nMismatched;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERSUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-level reference: wide unsigned subtraction gives diff and borrow
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    exp_t e;
    logic [WIDTH:0] wide;
    wide = {1'b0, av} - {1'b0, bv};
    e.d  = wide[WIDTH-1:0];
    e.br = wide[WIDTH];
    e.ov = (av[WIDTH-1] != bv[WIDTH-1]) && (wide[WIDTH-1] != av[WIDTH-1]);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic popCompare(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput({tag, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    e = expQ.pop_front();
    checkOutput({tag, " diff"}, 32'(diff), 32'(e.d));
    checkOutput({tag, " borrow"}, 32'(borrow), 32'(e.br));
`ifdef SERSUB_OVF_EN
    checkOutput({tag, " ovf"}, 32'(ovf), 32'(e.ov));
`endif
  endtask

  // Called #1 after the accepting edge: bounded wait for done, checking
  // latency, result, busy length and single-cycle done
  task automatic waitAndCheck(input string tag);
    int s;
    int busyCycles;
    s = 0;
    busyCycles = 0;
    while (done !== 1'b1 && s < 40) begin
      if (busy === 1'b1) busyCycles++;
      @(posedge clk); #1;
      s++;
    end
    checkOutput({tag, " done latency"}, 32'(s), 32'(WIDTH));
    popCompare(tag);
    while (busy === 1'b1 && s < 40) begin
      busyCycles++;
      @(posedge clk); #1;
      s++;
    end
    checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'(WIDTH + 1));
    checkOutput({tag, " done cleared"}, 32'(done), 32'd0);
  endtask

  // Launch one operation with a one-cycle start pulse; operands are
  // scrambled right after acceptance to prove they were latched
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input string tag);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    expQ.push_back(model(av, bv));
    @(posedge clk); #1;
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    checkOutput({tag, " busy after accept"}, 32'(busy), 32'd1);
    waitAndCheck(tag);
  endtask

  initial begin
    int pulses;
    nCompared = 0;
    nMismatched = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;

    #2;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset diff", 32'(diff), 32'd0);
    checkOutput("reset borrow", 32'(borrow), 32'd0);
`ifdef SERSUB_OVF_EN
    checkOutput("reset ovf", 32'(ovf), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic and directed operand cases
    applyStimulus(8'd5, 8'd3, "5-3");
    $display("[TB] 5-3 done");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle hold diff", 32'(diff), 32'h02);
    checkOutput("idle hold busy", 32'(busy), 32'd0);
    applyStimulus(8'd3, 8'd5, "3-5");
    applyStimulus(8'h80, 8'h01, "80-01");
    applyStimulus(8'h00, 8'h00, "00-00");
    applyStimulus(8'h00, 8'hFF, "00-FF");

    // Start held high; operands change during RUN
    @(negedge clk);
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    expQ.push_back(model(8'h10, 8'h01));
    @(posedge clk); #1;
    a = 8'h55;
    b = 8'h22;
    expQ.push_back(model(8'h55, 8'h22));
    pulses = 0;
    for (int k = 1; k <= WIDTH + 2; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
      if (k == WIDTH) begin
        checkOutput("hold done at E8", 32'(done), 32'd1);
        checkOutput("hold diff literal", 32'(diff), 32'h0F);
        popCompare("hold first");
      end
      if (k == WIDTH + 1) checkOutput("hold idle gap busy", 32'(busy), 32'd0);
      if (k == WIDTH + 2) checkOutput("hold reaccept busy", 32'(busy), 32'd1);
    end
    checkOutput("hold single done pulse", 32'(pulses), 32'd1);
    start = 1'b0;
    waitAndCheck("hold second");

    // Reset in the middle of RUN aborts the operation
    @(negedge clk);
    a = 8'h77;
    b = 8'h11;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort diff", 32'(diff), 32'd0);
    checkOutput("abort borrow", 32'(borrow), 32'd0);
`ifdef SERSUB_OVF_EN
    checkOutput("abort ovf", 32'(ovf), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    checkOutput("abort no done pulse", 32'(pulses), 32'd0);
    applyStimulus(8'h64, 8'h32, "64-32");
    checkOutput("post reset diff literal", 32'(diff), 32'h32);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
